// File: rtl/ctr_pkg.sv
// Shared constants and helpers for the counter/timer primitives.
package ctr_pkg;

  // Direction encoding for up_dn.
  localparam logic CTR_DN = 1'b0;
  localparam logic CTR_UP = 1'b1;

  // Bits needed to hold values 0..value-1 (at least 1 bit).
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        bits = bits + 1;
        rem  = rem >> 1;
      end
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles.
// clr restarts the phase. With en low the phase is held.
module tick_gen
  import ctr_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("tick_gen: PRESCALE must be >= 1");
    end
  endgenerate

  logic [PW-1:0] r_pre;
  logic          w_tick;

  assign w_tick = en & (r_pre == PRE_LAST);
  assign tick   = w_tick;

  // Phase accumulator: clear on reset/clr, wrap on tick, hold when disabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= r_pre + 1'b1;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with enable, parallel load,
// prescaler, wrap/saturate mode and tc/wrap/step flags.
module mod_updown_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             step
);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_step;

  logic             w_tick;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_hit;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_step_val;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (w_tick)
  );

  assign w_at_max       = (r_count == CNT_MAX);
  assign w_at_min       = (r_count == '0);
  assign w_hit          = (up_dn == CTR_UP) ? w_at_max : w_at_min;
  assign w_load_clamped = (load_val > CNT_MAX) ? CNT_MAX : load_val;

  // Next value for a step; the limit is tested before add/sub so the
  // arithmetic never leaves 0..MODULUS-1 (covers MODULUS == 2**WIDTH too).
  always_comb begin
    w_step_val = r_count;
    if (up_dn == CTR_UP) begin
      if (w_at_max) begin
        w_step_val = (SATURATE != 0) ? r_count : '0;
      end else begin
        w_step_val = r_count + 1'b1;
      end
    end else begin
      if (w_at_min) begin
        w_step_val = (SATURATE != 0) ? r_count : CNT_MAX;
      end else begin
        w_step_val = r_count - 1'b1;
      end
    end
  end

  // Count and flag registers: reset > load > step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_step  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_wrap  <= 1'b0;
      r_step  <= 1'b0;
    end else if (w_tick) begin
      r_count <= w_step_val;
      r_wrap  <= w_hit;
      r_step  <= 1'b1;
    end else begin
      r_wrap  <= 1'b0;
      r_step  <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign step  = r_step;
  assign tc    = ((up_dn == CTR_UP) & w_at_max) | ((up_dn == CTR_DN) & w_at_min);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four configurations share one stimulus
// stream; each is compared every cycle against an arithmetic model.
module tb_mod_updown_counter;

  localparam int W  = 4;
  localparam int NI = 4;

  // Configurations: {MODULUS, PRESCALE, SATURATE}
  localparam int M0 = 10, P0 = 1, S0 = 0;
  localparam int M1 = 10, P1 = 1, S1 = 1;
  localparam int M2 = 10, P2 = 3, S2 = 0;
  localparam int M3 = 16, P3 = 2, S3 = 0;

  int cfg_mod [NI] = '{M0, M1, M2, M3};
  int cfg_pre [NI] = '{P0, P1, P2, P3};
  int cfg_sat [NI] = '{S0, S1, S2, S3};

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset    = 1'b1;
  logic         en       = 1'b0;
  logic         up_dn    = 1'b1;
  logic         load     = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] cnt_w [NI];
  logic [NI-1:0] tc_w;
  logic [NI-1:0] wrap_w;
  logic [NI-1:0] step_w;

  mod_updown_counter #(.WIDTH(W), .MODULUS(M0), .PRESCALE(P0), .SATURATE(S0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_w[0]), .tc(tc_w[0]), .wrap(wrap_w[0]), .step(step_w[0]));
  mod_updown_counter #(.WIDTH(W), .MODULUS(M1), .PRESCALE(P1), .SATURATE(S1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_w[1]), .tc(tc_w[1]), .wrap(wrap_w[1]), .step(step_w[1]));
  mod_updown_counter #(.WIDTH(W), .MODULUS(M2), .PRESCALE(P2), .SATURATE(S2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_w[2]), .tc(tc_w[2]), .wrap(wrap_w[2]), .step(step_w[2]));
  mod_updown_counter #(.WIDTH(W), .MODULUS(M3), .PRESCALE(P3), .SATURATE(S3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_w[3]), .tc(tc_w[3]), .wrap(wrap_w[3]), .step(step_w[3]));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q [$];   // directed expectations for instance 0/1 counts

  // Reference model state.
  int m_cnt  [NI];
  int m_en_n [NI];   // enabled cycles since last clear, modulo PRESCALE
  int m_wrap [NI];
  int m_step [NI];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_tc(input int k);
    if (up_dn) return (m_cnt[k] == cfg_mod[k] - 1) ? 1 : 0;
    return (m_cnt[k] == 0) ? 1 : 0;
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      int m;
      int tick;
      int limit;
      m = cfg_mod[k];
      if (reset) begin
        m_cnt[k] = 0; m_en_n[k] = 0; m_wrap[k] = 0; m_step[k] = 0;
      end else if (load) begin
        m_cnt[k]  = (int'(load_val) > m - 1) ? m - 1 : int'(load_val);
        m_en_n[k] = 0; m_wrap[k] = 0; m_step[k] = 0;
      end else begin
        tick = 0;
        if (en) begin
          m_en_n[k] = (m_en_n[k] + 1) % cfg_pre[k];
          tick = (m_en_n[k] == 0) ? 1 : 0;
        end
        if (tick) begin
          limit     = up_dn ? m - 1 : 0;
          m_wrap[k] = (m_cnt[k] == limit) ? 1 : 0;
          m_step[k] = 1;
          if (!(m_wrap[k] && cfg_sat[k] != 0))
            m_cnt[k] = up_dn ? (m_cnt[k] + 1) % m : (m_cnt[k] + m - 1) % m;
        end else begin
          m_wrap[k] = 0; m_step[k] = 0;
        end
      end
    end
  endtask

  task automatic check_tc();
    for (int k = 0; k < NI; k++)
      check_val($sformatf("tc%0d", k), int'(tc_w[k]), model_tc(k));
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("count%0d", k), int'(cnt_w[k]), m_cnt[k]);
      check_val($sformatf("wrap%0d", k), int'(wrap_w[k]), m_wrap[k]);
      check_val($sformatf("step%0d", k), int'(step_w[k]), m_step[k]);
    end
    check_tc();
  endtask

  // ---------------- driver tasks ----------------
  // One cycle; sel chooses which instance exp_q is checked against (-1 none).
  task automatic drive_cycle(input logic r, input logic e, input logic u,
                             input logic l, input logic [W-1:0] v,
                             input int sel, input logic [W-1:0] exp_cnt);
    reset = r; en = e; up_dn = u; load = l; load_val = v;
    if (sel >= 0) exp_q.push_back(exp_cnt);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (sel >= 0) begin
      logic [W-1:0] e_cnt;
      e_cnt = exp_q.pop_front();
      check_val($sformatf("dir_count%0d", sel), int'(cnt_w[sel]), int'(e_cnt));
    end
  endtask

  task automatic run(input logic r, input logic e, input logic u,
                     input logic l, input logic [W-1:0] v);
    drive_cycle(r, e, u, l, v, -1, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] seq_up [12];
    logic [W-1:0] seq_dn [5];
    logic [W-1:0] seq_sat [5];
    logic [W-1:0] seq_tog [4];
    seq_up  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    seq_dn  = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    seq_sat = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    seq_tog = '{4'd6, 4'd5, 4'd6, 4'd5};
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = 0; m_en_n[k] = 0; m_wrap[k] = 0; m_step[k] = 0;
    end

    // Reset for two cycles.
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 0, 4'd0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 0, 4'd0);

    // Count up through the modulus boundary.
    for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 0, seq_up[i]);

    // Load 3 while disabled, then count down through 0.
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 0, 4'd3);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 0, seq_dn[i]);

    // Saturation on instance 1: up from 7, then down from 0.
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 1, 4'd7);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1, seq_sat[i]);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1, 4'd0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1, 4'd0);

    // Prescaler: 9 enabled cycles, a 2-cycle pause mid-phase, load mid-phase.
    run(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 9; i++) run(1'b0, 1'b1, 1'b1, 1'b0, '0);
    run(1'b0, 1'b1, 1'b1, 1'b0, '0);
    run(1'b0, 1'b0, 1'b1, 1'b0, '0);
    run(1'b0, 1'b0, 1'b1, 1'b0, '0);
    run(1'b0, 1'b1, 1'b1, 1'b0, '0);
    run(1'b0, 1'b1, 1'b1, 1'b1, 4'd4);
    for (int i = 0; i < 4; i++) run(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Priority: reset beats load+en; load clamps; load beats a tick.
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 0, 4'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 0, 4'd9);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 0, 4'd2);

    // Direction toggling every cycle from 5.
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 0, 4'd5);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, ~i[0], 1'b0, '0, 0, seq_tog[i]);

    // tc follows up_dn without a clock edge at both boundaries.
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 0, 4'd0);
    up_dn = 1'b1; #1; check_tc();
    up_dn = 1'b0; #1; check_tc();
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 0, 4'd9);
    up_dn = 1'b0; #1; check_tc();
    up_dn = 1'b1; #1; check_tc();

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      run(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
          W'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
